imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a framed byte stream.
// A frame is SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of four bytes each,
// least-significant byte first. The CPU is held in reset while a frame loads.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid, in_data   byte stream in (accepted when in_valid && in_ready)
//   in_ready            loader can take a byte (low only during a write cycle)
//   wr_en               imem write strobe, one cycle per assembled word
//   wr_addr, wr_data    imem word address / data, held between writes
//   cpu_hold            hold the CPU in reset while loading or after an error
//   done, error         status of the most recent frame (levels)
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned TIMEOUT    = 1024,
    parameter bit          BOOT_HOLD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned TMO_W = 16;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [7:0]         len_lo;
    logic [CNT_W-1:0]   n_words;
    logic [CNT_W-1:0]   word_idx;
    logic [1:0]         byte_cnt;
    logic [23:0]        word_buf;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               accept;
    logic               is_sync;
    logic               tmo_hit;
    logic               tmo_run;
    logic [15:0]        len_n;
    logic               last_word;

    logic               in_ready_d;
    logic               wr_en_d;
    logic               cpu_hold_d;
    logic               done_d;
    logic               error_d;

    assign accept    = in_valid && in_ready;
    assign is_sync   = (in_data == SYNC_BYTE);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign tmo_run   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign len_n     = {in_data, len_lo};
    assign last_word = (word_idx == (n_words - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; an accepted byte takes priority over a timeout
    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (accept && is_sync) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    state_d = LEN_HI;
                end else if (tmo_hit) begin
                    state_d = ERROR;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_n == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_n} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end else if (tmo_hit) begin
                    state_d = ERROR;
                end
            end
            DATA: begin
                if (accept) begin
                    if (byte_cnt == 2'd3) begin
                        state_d = WRITE;
                    end
                end else if (tmo_hit) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                state_d = last_word ? DONE : DATA;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, decoded from the next state
    always_comb begin
        in_ready_d = (state_d != WRITE);
        wr_en_d    = (state_d == WRITE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
        cpu_hold_d = 1'b1;
        case (state_d)
            DONE:    cpu_hold_d = 1'b0;
            IDLE:    cpu_hold_d = cpu_hold;
            default: cpu_hold_d = 1'b1;
        endcase
    end

    // Output registers and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= BOOT_HOLD;
            done     <= 1'b0;
            error    <= 1'b0;
            len_lo   <= '0;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            tmo_cnt  <= '0;
        end else begin
            in_ready <= in_ready_d;
            wr_en    <= wr_en_d;
            cpu_hold <= cpu_hold_d;
            done     <= done_d;
            error    <= error_d;

            // Idle counter only runs mid-frame; any accepted byte restarts it
            if (tmo_run && !accept) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        n_words <= CNT_W'(len_n);
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word; strobe next cycle
                                wr_data <= {in_data, word_buf};
                                wr_addr <= word_idx[ADDR_WIDTH-1:0];
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + CNT_W'(1);
                end
                default: begin
                    if (accept && is_sync) begin
                        byte_cnt <= '0;
                        word_idx <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole frames plus hand-written
// sequences for maximum length, timeout, restart from DONE and mid-frame reset.
module tb_imem_loader;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned TIMEOUT    = 1024;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    imem_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT    (TIMEOUT),
        .BOOT_HOLD  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -10;
    logic prev_wr = 1'b0;
    logic [ADDR_WIDTH-1:0] log_a[$];
    logic [31:0]           log_d[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: logs every strobe and checks its timing rules
    always @(negedge clk) begin
        if (wr_en) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
            check("wr_latency", 32'(cyc), 32'(last_acc));
            check("ready_low_on_write", 32'(in_ready), 32'd0);
            check("wr_back_to_back", 32'(prev_wr), 32'd0);
        end
        prev_wr <= wr_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("ready_wait", 32'(in_ready), 32'd1);
        end
        tick();
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    typedef struct packed {
        logic [95:0] bytes;   // frame bytes, first byte in the top byte lane
        int          nbytes;
        int          nwr;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        exp_done;
        logic        exp_error;
        logic        exp_hold;
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        int base;
        logic [95:0] tmp;
        base = log_a.size();
        tmp  = v.bytes;
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(tmp[95-8*i -: 8]);
        end
        idle(4);
        check({name, "_nwr"}, 32'(log_a.size() - base), 32'(v.nwr));
        if (v.nwr >= 1 && log_a.size() > base) begin
            check({name, "_a0"}, 32'(log_a[base]), 32'(v.a0));
            check({name, "_d0"}, log_d[base], v.d0);
        end
        if (v.nwr >= 2 && log_a.size() > base + 1) begin
            check({name, "_a1"}, 32'(log_a[base+1]), 32'(v.a1));
            check({name, "_d1"}, log_d[base+1], v.d1);
        end
        check({name, "_done"}, 32'(done), 32'(v.exp_done));
        check({name, "_error"}, 32'(error), 32'(v.exp_error));
        check({name, "_hold"}, 32'(cpu_hold), 32'(v.exp_hold));
        check({name, "_wr_idle"}, 32'(wr_en), 32'd0);
    endtask

    vec_t vecs[6];
    vec_t rec;

    initial begin
        int base;
        logic [7:0] ib;

        // Frames applied back to back; each starts from the previous end state
        vecs[0] = '{bytes: {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00},
                    nbytes: 11, nwr: 2, a0: 8'd0, d0: 32'h12345678, a1: 8'd1, d1: 32'hDEADBEEF,
                    exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        vecs[1] = '{bytes: {8'h00, 8'hFF, 8'hA4, 8'hA5, 8'h01, 8'h00, 8'h0D, 8'hD0, 8'hFE, 8'hCA, 16'h0},
                    nbytes: 10, nwr: 1, a0: 8'd0, d0: 32'hCAFED00D, a1: 8'd0, d1: 32'h0,
                    exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        vecs[2] = '{bytes: {8'hA5, 8'h00, 8'h00, 72'h0},
                    nbytes: 3, nwr: 0, a0: 8'd0, d0: 32'h0, a1: 8'd0, d1: 32'h0,
                    exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        vecs[3] = '{bytes: {8'hA5, 8'h01, 8'h01, 72'h0},
                    nbytes: 3, nwr: 0, a0: 8'd0, d0: 32'h0, a1: 8'd0, d1: 32'h0,
                    exp_done: 1'b0, exp_error: 1'b1, exp_hold: 1'b1};
        vecs[4] = '{bytes: {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 40'h0},
                    nbytes: 7, nwr: 1, a0: 8'd0, d0: 32'h44332211, a1: 8'd0, d1: 32'h0,
                    exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        vecs[5] = '{bytes: {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 40'h0},
                    nbytes: 7, nwr: 1, a0: 8'd0, d0: 32'hA5A5A5A5, a1: 8'd0, d1: 32'h0,
                    exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_hold", 32'(cpu_hold), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Maximum length: 2**ADDR_WIDTH words fill every address exactly once
        base = log_a.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        for (int w = 0; w < 256; w++) begin
            ib = 8'(w);
            send_byte(ib);
            send_byte(~ib);
            send_byte(8'h5A);
            send_byte(8'hC3);
        end
        idle(4);
        check("max_nwr", 32'(log_a.size() - base), 32'd256);
        for (int w = 0; w < 256 && base + w < log_a.size(); w++) begin
            ib = 8'(w);
            check($sformatf("max_a%0d", w), 32'(log_a[base+w]), 32'(ib));
            check($sformatf("max_d%0d", w), log_d[base+w], {8'hC3, 8'h5A, ~ib, ib});
        end
        check("max_done", 32'(done), 32'd1);

        // Timeout after two data bytes: error exactly TIMEOUT idle cycles later
        base = log_a.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TIMEOUT - 1);
        check("tmo_early", 32'(error), 32'd0);
        tick();
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        check("tmo_nwr", 32'(log_a.size() - base), 32'd0);
        rec = vecs[4];
        run_vec(rec, "tmo_recover");

        // Restart from DONE: hold rises on the accepted sync byte
        base = log_a.size();
        send_byte(8'hA5);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        idle(4);
        check("restart_nwr", 32'(log_a.size() - base), 32'd1);
        if (log_a.size() > base) begin
            check("restart_d0", log_d[base], 32'h88776655);
        end
        check("restart_done2", 32'(done), 32'd1);

        // Reset after three data bytes: back to reset values, nothing written
        base = log_a.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("mrst_hold", 32'(cpu_hold), 32'd1);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_error", 32'(error), 32'd0);
        check("mrst_wr_en", 32'(wr_en), 32'd0);
        check("mrst_wr_addr", 32'(wr_addr), 32'd0);
        check("mrst_wr_data", wr_data, 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        idle(4);
        check("mrst_nwr", 32'(log_a.size() - base), 32'd0);
        check("mrst_ready_after", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
